if_id_pipe_elastic: RTL and testbench

Parametrised successor to the fixed IF/ID stage register for the multi-issue front end. It carries a bundle of LANES fetch slots from IF to ID and replaces the single IF_ID_write enable with a valid/ready handshake. A 2-entry elastic buffer (main + skid) lets IF stay registered while ID back-pressures, without a combinational ready path. Synchronous flush drops all in-flight bundles on a redirect.

---
 rtl/if_id_pipe_elastic.sv | 154 +++++++++++++++
 tb/tb_if_id_pipe_elastic.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_pipe_elastic.sv
// ---------------------------------------------------------------------------
// if_id_pipe_elastic : IF->ID bundle register, 2-entry elastic (main + skid)
// Optional lane compaction on capture with `define IFID_COMPACT_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module if_id_pipe_elastic #(
  parameter int LANES     = 2,
  parameter int PAYLOAD_W = 128
) (
  input  logic                         clk,
  input  logic                         Reset,
  input  logic                         flush,
  input  logic [LANES-1:0]             in_valid,
  input  logic [LANES*PAYLOAD_W-1:0]   in_payload,
  output logic                         in_ready,
  output logic [LANES-1:0]             out_valid,
  output logic [LANES*PAYLOAD_W-1:0]   out_payload,
  input  logic                         out_ready,
  output logic [1:0]                   occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic                         in_ready_q, in_ready_d;
  logic [LANES-1:0]             main_valid_q, main_valid_d;
  logic [LANES*PAYLOAD_W-1:0]   main_payload_q, main_payload_d;
  logic [LANES-1:0]             skid_valid_q, skid_valid_d;
  logic [LANES*PAYLOAD_W-1:0]   skid_payload_q, skid_payload_d;

  logic                         accept;
  logic                         fire;
  logic [LANES-1:0]             cap_valid;
  logic [LANES*PAYLOAD_W-1:0]   cap_payload;

`ifdef IFID_COMPACT_EN
  // Each valid lane lands in the slot equal to the count of valid lanes below it.
  always_comb begin
    int pos;
    pos         = 0;
    cap_valid   = '0;
    cap_payload = '0;
    for (int i = 0; i < LANES; i++) begin
      pos = 0;
      for (int k = 0; k < i; k++) begin
        pos = pos + int'(in_valid[k]);
      end
      for (int j = 0; j < LANES; j++) begin
        if (in_valid[i] && (pos == j)) begin
          cap_valid[j]                            = 1'b1;
          cap_payload[j*PAYLOAD_W +: PAYLOAD_W]   = in_payload[i*PAYLOAD_W +: PAYLOAD_W];
        end
      end
    end
  end
`else
  always_comb begin
    cap_valid   = in_valid;
    cap_payload = in_payload;
  end
`endif

  always_comb begin
    accept         = in_ready_q && (|in_valid);
    fire           = out_ready && (state_q != EMPTY);
    state_d        = state_q;
    main_valid_d   = main_valid_q;
    main_payload_d = main_payload_q;
    skid_valid_d   = skid_valid_q;
    skid_payload_d = skid_payload_q;

    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d        = ONE;
          main_valid_d   = cap_valid;
          main_payload_d = cap_payload;
        end
      end
      ONE: begin
        if (accept && fire) begin
          main_valid_d   = cap_valid;
          main_payload_d = cap_payload;
        end else if (accept) begin
          state_d        = TWO;
          skid_valid_d   = cap_valid;
          skid_payload_d = cap_payload;
        end else if (fire) begin
          state_d        = EMPTY;
          main_valid_d   = '0;
          main_payload_d = '0;
        end
      end
      TWO: begin
        if (fire) begin
          state_d        = ONE;
          main_valid_d   = skid_valid_q;
          main_payload_d = skid_payload_q;
          skid_valid_d   = '0;
          skid_payload_d = '0;
        end
      end
      default: begin
        state_d        = EMPTY;
        main_valid_d   = '0;
        main_payload_d = '0;
        skid_valid_d   = '0;
        skid_payload_d = '0;
      end
    endcase

    if (flush) begin
      state_d        = EMPTY;
      main_valid_d   = '0;
      main_payload_d = '0;
      skid_valid_d   = '0;
      skid_payload_d = '0;
    end

    // Ready is a function of the next state only, so it never sees out_ready combinationally.
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q        <= EMPTY;
      in_ready_q     <= 1'b1;
      main_valid_q   <= '0;
      main_payload_q <= '0;
      skid_valid_q   <= '0;
      skid_payload_q <= '0;
    end else begin
      state_q        <= state_d;
      in_ready_q     <= in_ready_d;
      main_valid_q   <= main_valid_d;
      main_payload_q <= main_payload_d;
      skid_valid_q   <= skid_valid_d;
      skid_payload_q <= skid_payload_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_valid_q;
  assign out_payload = main_payload_q;
  assign occupancy   = state_q;

endmodule

`default_nettype wire

// File: tb/tb_if_id_pipe_elastic.sv
// Testbench for if_id_pipe_elastic: directed scenarios plus random traffic
// checked against a queue-based model of the elastic buffer.
`default_nettype none

module tb_if_id_pipe_elastic;
  localparam int LANES     = 2;
  localparam int PAYLOAD_W = 128;
  localparam int LW        = LANES * PAYLOAD_W;
  localparam int VW        = 3 + LANES + LW;

  logic              clk = 1'b0;
  logic              Reset, flush, out_ready, in_ready;
  logic [LANES-1:0]  in_valid, out_valid;
  logic [LW-1:0]     in_payload, out_payload;
  logic [1:0]        occupancy;

  int total = 0;
  int bad   = 0;

  logic [LANES-1:0]  mq_v[$];
  logic [LW-1:0]     mq_p[$];

  always #5 clk = ~clk;

  if_id_pipe_elastic #(.LANES(LANES), .PAYLOAD_W(PAYLOAD_W)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_payload (in_payload),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_payload(out_payload),
    .out_ready  (out_ready),
    .occupancy  (occupancy)
  );

  function automatic logic [LW-1:0] rand_payload();
    logic [LW-1:0] r;
    for (int i = 0; i < LW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic void pack(input logic [LANES-1:0] v, input logic [LW-1:0] p,
                               output logic [LANES-1:0] ov, output logic [LW-1:0] op);
`ifdef IFID_COMPACT_EN
    int n;
    n  = 0;
    ov = '0;
    op = '0;
    for (int i = 0; i < LANES; i++) begin
      if (v[i]) begin
        ov[n] = 1'b1;
        op[n*PAYLOAD_W +: PAYLOAD_W] = p[i*PAYLOAD_W +: PAYLOAD_W];
        n++;
      end
    end
`else
    ov = v;
    op = p;
`endif
  endfunction

  // FIFO of up to two bundles; the head is what ID sees.
  function automatic void model_update();
    logic [LANES-1:0] pv;
    logic [LW-1:0]    pp;
    bit               acc, fire;
    if (Reset || flush) begin
      mq_v.delete();
      mq_p.delete();
    end else begin
      acc  = (mq_v.size() < 2) && (in_valid != '0);
      fire = out_ready && (mq_v.size() > 0);
      if (fire) begin
        void'(mq_v.pop_front());
        void'(mq_p.pop_front());
      end
      if (acc) begin
        pack(in_valid, in_payload, pv, pp);
        mq_v.push_back(pv);
        mq_p.push_back(pp);
      end
    end
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [1:0]       occ;
    logic             rdy;
    logic [LANES-1:0] v;
    logic [LW-1:0]    p;
    occ = 2'(mq_v.size());
    rdy = (mq_v.size() < 2);
    v   = (mq_v.size() > 0) ? mq_v[0] : '0;
    p   = (mq_p.size() > 0) ? mq_p[0] : '0;
    return {occ, rdy, v, p};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    Reset = 1'b0; flush = 1'b0; in_valid = '0; in_payload = '0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    in_valid = 2'b11;
    repeat (2) begin in_payload = rand_payload(); tick(); end
    total++;
    if (occupancy !== 2'd2) begin bad++; $display("FAIL reset_prefill: occupancy=%0d want 2", occupancy); end
    in_valid = '0; Reset = 1'b1;
    tick();
    Reset = 1'b0;
    total++;
    if ({occupancy, in_ready, out_valid, out_payload} !== {2'd0, 1'b1, {LANES{1'b0}}, {LW{1'b0}}}) begin
      bad++; $display("FAIL reset_state: occ=%0d rdy=%b v=%b p=%h", occupancy, in_ready, out_valid, out_payload);
    end
    total++;
    if ({occupancy, in_ready, out_valid, out_payload} !== exp_vec()) begin
      bad++; $display("FAIL reset_model: got %h want %h", {occupancy, in_ready, out_valid, out_payload}, exp_vec());
    end
  endtask

  task automatic test_streaming();
    idle();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid   = 2'b11;
      in_payload = rand_payload();
      in_payload[PAYLOAD_W-1:0] = PAYLOAD_W'(32'h1000 + k);
      tick();
      total++;
      if (out_payload[PAYLOAD_W-1:0] !== PAYLOAD_W'(32'h1000 + k) || out_valid !== 2'b11 || in_ready !== 1'b1) begin
        bad++; $display("FAIL stream_%0d: lane0=%h v=%b rdy=%b want lane0=%h v=11 rdy=1",
                        k, out_payload[PAYLOAD_W-1:0], out_valid, in_ready, 32'h1000 + k);
      end
      total++;
      if ({occupancy, in_ready, out_valid, out_payload} !== exp_vec()) begin
        bad++; $display("FAIL stream_model_%0d: got %h want %h", k, {occupancy, in_ready, out_valid, out_payload}, exp_vec());
      end
    end
    in_valid = '0;
    tick();
    total++;
    if (occupancy !== 2'd0 || out_valid !== '0) begin
      bad++; $display("FAIL stream_drain: occ=%0d v=%b want 0 00", occupancy, out_valid);
    end
  endtask

  task automatic test_back_pressure();
    logic [LW-1:0] a, b;
    idle();
    a = rand_payload(); b = rand_payload();
    in_valid = 2'b11; in_payload = a; tick();
    in_payload = b; tick();
    in_valid = '0;
    total++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_payload !== a) begin
      bad++; $display("FAIL bp_full: occ=%0d rdy=%b p=%h want occ=2 rdy=0 p=%h", occupancy, in_ready, out_payload, a);
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_payload !== b) begin
      bad++; $display("FAIL bp_second: occ=%0d rdy=%b p=%h want occ=1 rdy=1 p=%h", occupancy, in_ready, out_payload, b);
    end
    tick();
    total++;
    if ({occupancy, in_ready, out_valid, out_payload} !== exp_vec() || occupancy !== 2'd0) begin
      bad++; $display("FAIL bp_empty: got %h want %h", {occupancy, in_ready, out_valid, out_payload}, exp_vec());
    end
  endtask

  task automatic test_flush_collision();
    idle();
    in_valid = 2'b11;
    repeat (2) begin in_payload = rand_payload(); tick(); end
    flush = 1'b1; in_payload = rand_payload();
    tick();
    flush = 1'b0; in_valid = '0;
    total++;
    if (occupancy !== 2'd0 || out_valid !== '0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_state: occ=%0d v=%b rdy=%b want 0 00 1", occupancy, out_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (out_valid !== '0 || occupancy !== 2'd0) begin
        bad++; $display("FAIL flush_ghost_%0d: v=%b occ=%0d want 00 0", i, out_valid, occupancy);
      end
    end
  endtask

  task automatic test_empty_bundle();
    idle();
    in_valid = 2'b01; in_payload = rand_payload(); tick();
    in_valid = 2'b00; in_payload = rand_payload();
    repeat (2) tick();
    total++;
    if (occupancy !== 2'd1 || {occupancy, in_ready, out_valid, out_payload} !== exp_vec()) begin
      bad++; $display("FAIL empty_bundle: got %h want %h", {occupancy, in_ready, out_valid, out_payload}, exp_vec());
    end
    out_ready = 1'b1; tick();
  endtask

  task automatic test_compaction();
    logic [LANES-1:0] ev;
    logic [LW-1:0]    ep;
    idle();
    in_valid   = 2'b10;
    in_payload = {PAYLOAD_W'(32'hABCD), PAYLOAD_W'(32'h5555)};
`ifdef IFID_COMPACT_EN
    ev = 2'b01;
    ep = {PAYLOAD_W'(0), PAYLOAD_W'(32'hABCD)};
`else
    ev = 2'b10;
    ep = {PAYLOAD_W'(32'hABCD), PAYLOAD_W'(32'h5555)};
`endif
    tick();
    in_valid = '0;
    total++;
    if (out_valid !== ev || out_payload !== ep) begin
      bad++; $display("FAIL compaction: v=%b p=%h want v=%b p=%h", out_valid, out_payload, ev, ep);
    end
    out_ready = 1'b1; tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      Reset      = ($urandom_range(0, 49) == 0);
      flush      = ($urandom_range(0, 15) == 0);
      in_valid   = LANES'($urandom);
      in_payload = rand_payload();
      out_ready  = ($urandom_range(0, 2) != 0);
      tick();
      total++;
      if ({occupancy, in_ready, out_valid, out_payload} !== exp_vec()) begin
        bad++; $display("FAIL random_%0d: got %h want %h", i, {occupancy, in_ready, out_valid, out_payload}, exp_vec());
      end
    end
    idle();
  endtask

  initial begin
    idle();
    Reset = 1'b1;
    repeat (2) tick();
    Reset = 1'b0;
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush_collision();
    test_empty_bundle();
    test_compaction();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
